// File: rtl/cls_pkg.sv
// Shared constants, FSM state encoding and result payload for the frame classifier controller.
package cls_pkg;
    localparam int unsigned NFEAT   = 7;
    localparam int unsigned FW      = 5;
    localparam int unsigned NCLS    = 3;
    localparam int unsigned CW      = 2;
    localparam int unsigned VW      = 2 * NCLS;
    localparam int unsigned FRAME_W = NFEAT * FW;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RESULT  = 2'd2
    } cls_state_e;

    typedef struct packed {
        logic [CW-1:0] cls;
        logic [VW-1:0] votes;
        logic          err;
    } cls_res_t;
endpackage

// File: rtl/cls_frame_ctrl_if.sv
// Feature stream, classifier tap and result handshake of cls_frame_ctrl.
interface cls_frame_ctrl_if;
    import cls_pkg::*;

    logic               feat_valid;
    logic [FW-1:0]      feat_data;
    logic               feat_last;
    logic               feat_ready;
    logic [FRAME_W-1:0] cls_inp;
    logic [CW-1:0]      cls_out;
    logic [VW-1:0]      cls_predo;
    logic               res_valid;
    logic               res_ready;
    logic [CW-1:0]      res_class;
    logic [VW-1:0]      res_votes;
    logic               res_err;

    modport slave (
        input  feat_valid, feat_data, feat_last, cls_out, cls_predo, res_ready,
        output feat_ready, cls_inp, res_valid, res_class, res_votes, res_err
    );

    modport master (
        output feat_valid, feat_data, feat_last, cls_out, cls_predo, res_ready,
        input  feat_ready, cls_inp, res_valid, res_class, res_votes, res_err
    );
endinterface

// File: rtl/cls_settle_timer.sv
// Loadable down-counter: done rises one cycle after the count has reached zero while enabled.
module cls_settle_timer #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (load) begin
            cnt_q <= CNT_W'(SETTLE_CYC - 1);
            done  <= 1'b0;
        end else if (en) begin
            if (cnt_q == '0) begin
                done <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/cls_frame_ctrl.sv
// Collects a feature frame for a combinational classifier and hands back its registered verdict.
// Define CLS_SETTLE_EN to wait SETTLE_CYC extra cycles for the classifier before capture.
module cls_frame_ctrl #(
    parameter int unsigned NFEAT      = 7,
    parameter int unsigned FW         = 5,
    parameter int unsigned NCLS       = 3,
    parameter int unsigned SETTLE_CYC = 4
) (
    input logic             clk,
    input logic             rst_n,
    cls_frame_ctrl_if.slave bus
);
    import cls_pkg::*;

    localparam int unsigned IW        = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam logic [1:0]  S_COLLECT = 2'(ST_COLLECT);
`ifdef CLS_SETTLE_EN
    localparam logic [1:0]  S_SETTLE  = 2'(ST_SETTLE);
`endif
    localparam logic [1:0]  S_RESULT  = 2'(ST_RESULT);

    // The interface is sized by cls_pkg, so overrides must agree with it.
    if (NFEAT != cls_pkg::NFEAT || FW != cls_pkg::FW || NCLS != cls_pkg::NCLS
        || SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_param_check
        $error("cls_frame_ctrl: parameters must match cls_pkg and SETTLE_CYC must be 1..15");
    end

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [IW-1:0]      idx_q;
    logic               err_q;
    logic [FRAME_W-1:0] inp_q;
    logic               feat_ready_q;
    logic               res_valid_q;
    cls_res_t           res_q;

    logic               feat_hs_c;
    logic               frame_end_c;
    logic               frame_err_c;
    logic               capture_c;
    logic               res_hs_c;

`ifdef CLS_SETTLE_EN
    logic               settle_done_c;

    cls_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (frame_end_c),
        .en   (state_q == S_SETTLE),
        .done (settle_done_c)
    );
`endif

    // Next state and per-cycle strobes.
    always_comb begin
        state_d     = state_q;
        feat_hs_c   = 1'b0;
        frame_end_c = 1'b0;
        frame_err_c = 1'b0;
        capture_c   = 1'b0;
        res_hs_c    = 1'b0;
        case (state_q)
            S_COLLECT: begin
                feat_hs_c   = bus.feat_valid && feat_ready_q;
                frame_end_c = feat_hs_c && (bus.feat_last || (idx_q == IW'(NFEAT - 1)));
                // A good frame ends with feat_last exactly on the last slot.
                frame_err_c = (idx_q == IW'(NFEAT - 1)) != bus.feat_last;
                if (frame_end_c) begin
`ifdef CLS_SETTLE_EN
                    state_d = S_SETTLE;
`else
                    state_d = S_RESULT;
`endif
                end
            end
`ifdef CLS_SETTLE_EN
            S_SETTLE: begin
                if (settle_done_c) begin
                    capture_c = 1'b1;
                    state_d   = S_RESULT;
                end
            end
`endif
            S_RESULT: begin
`ifndef CLS_SETTLE_EN
                capture_c = !res_valid_q;
`endif
                res_hs_c = res_valid_q && bus.res_ready;
                if (res_hs_c) begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_COLLECT;
            feat_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            feat_ready_q <= (state_d == S_COLLECT);
        end
    end

    // Frame buffer, length/error tracking and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            err_q       <= 1'b0;
            inp_q       <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            if (feat_hs_c) begin
                for (int unsigned k = 0; k < NFEAT; k++) begin
                    if (idx_q == IW'(k)) begin
                        inp_q[FW*k +: FW] <= bus.feat_data;
                    end
                end
                idx_q <= idx_q + IW'(1);
                if (frame_end_c) begin
                    err_q <= frame_err_c;
                end
            end
            if (capture_c) begin
                res_q.cls   <= bus.cls_out;
                res_q.votes <= bus.cls_predo;
                res_q.err   <= err_q;
                res_valid_q <= 1'b1;
            end
            if (res_hs_c) begin
                inp_q       <= '0;
                idx_q       <= '0;
                err_q       <= 1'b0;
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.feat_ready = feat_ready_q;
    assign bus.cls_inp    = inp_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_class  = res_q.cls;
    assign bus.res_votes  = res_q.votes;
    assign bus.res_err    = res_q.err;
endmodule

// File: tb/tb_cls_frame_ctrl.sv
// Self-checking bench for cls_frame_ctrl: directed frame table, reset corners and random frames.
module tb_cls_frame_ctrl;
    import cls_pkg::*;

    localparam int unsigned SETTLE = 4;
`ifdef CLS_SETTLE_EN
    localparam int unsigned LAT = SETTLE + 1;
`else
    localparam int unsigned LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic          stub_ovr;
    logic [CW-1:0] ovr_cls;
    logic [VW-1:0] ovr_votes;

    cls_frame_ctrl_if bus ();

    cls_frame_ctrl #(
        .NFEAT     (NFEAT),
        .FW        (FW),
        .NCLS      (NCLS),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tiny three-stump voting classifier: {argmax, votes class0, class1, class2}.
    function automatic logic [CW+VW-1:0] classify(input logic [FRAME_W-1:0] fr);
        int v[3];
        int am;
        v[0] = 0;
        v[1] = 0;
        v[2] = 0;
        if (fr[4:0] < 5'd8) v[2]++; else v[0]++;
        if (fr[9:5] < 5'd8) v[2]++; else v[1]++;
        if (fr[14:10] < 5'd16) v[0]++; else v[1]++;
        am = 0;
        for (int c = 1; c < 3; c++) if (v[c] > v[am]) am = c;
        return {2'(am), 2'(v[0]), 2'(v[1]), 2'(v[2])};
    endfunction

    always_comb begin
        if (stub_ovr) {bus.cls_out, bus.cls_predo} = {ovr_cls, ovr_votes};
        else          {bus.cls_out, bus.cls_predo} = classify(bus.cls_inp);
    end

    typedef struct {
        int                           n;
        bit                           last;
        logic [NFEAT-1:0][FW-1:0]     vals;
        logic [FRAME_W-1:0]           inp;
        logic [CW-1:0]                cls;
        logic [VW-1:0]                votes;
        logic                         err;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic junk();
        bus.feat_valid = 1'($urandom);
        bus.feat_data  = FW'($urandom);
        bus.feat_last  = 1'($urandom);
    endtask

    task automatic chk_reset(input string name);
        chk({name, ":feat_ready"}, 64'(bus.feat_ready), 64'(1));
        chk({name, ":cls_inp"}, 64'(bus.cls_inp), 64'(0));
        chk({name, ":res"}, 64'({bus.res_valid, bus.res_class, bus.res_votes, bus.res_err}), 64'(0));
    endtask

    task automatic send_raw(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            bus.feat_valid = 1'b1;
            bus.feat_data  = FW'(i + 3);
            bus.feat_last  = last && (i == n - 1);
            step();
        end
        bus.feat_valid = 1'b0;
        bus.feat_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic no_result(input string name, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            step();
            chk({name, ":no_res_valid"}, 64'(bus.res_valid), 64'(0));
        end
    endtask

    // Full frame: feed, wait for result with exact latency, optional hold, then result handshake.
    task automatic run_frame(input string name, input int n, input bit last,
                             input logic [NFEAT-1:0][FW-1:0] vals,
                             input logic [FRAME_W-1:0] exp_inp, input logic [CW-1:0] exp_cls,
                             input logic [VW-1:0] exp_votes, input logic exp_err,
                             input int hold, input bit scramble, input int max_gap);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                bus.feat_valid = 1'b0;
                bus.feat_data  = FW'($urandom);
                bus.feat_last  = 1'($urandom);
                step();
            end
            chk({name, ":feat_ready"}, 64'(bus.feat_ready), 64'(1));
            bus.feat_valid = 1'b1;
            bus.feat_data  = vals[i];
            bus.feat_last  = last && (i == n - 1);
            step();
        end
        junk();
        chk({name, ":ready_low"}, 64'(bus.feat_ready), 64'(0));
        chk({name, ":cls_inp"}, 64'(bus.cls_inp), 64'(exp_inp));
        for (int k = 1; k <= int'(LAT); k++) begin
            step();
            junk();
            chk({name, ":res_valid_lat"}, 64'(bus.res_valid), 64'(k == int'(LAT)));
        end
        chk({name, ":cls_inp_held"}, 64'(bus.cls_inp), 64'(exp_inp));
        chk({name, ":res_class"}, 64'(bus.res_class), 64'(exp_cls));
        chk({name, ":res_votes"}, 64'(bus.res_votes), 64'(exp_votes));
        chk({name, ":res_err"}, 64'(bus.res_err), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            if (scramble) begin
                stub_ovr  = 1'b1;
                ovr_cls   = CW'($urandom);
                ovr_votes = VW'($urandom);
            end
            junk();
            step();
            chk({name, ":hold_res"},
                64'({bus.res_valid, bus.res_class, bus.res_votes, bus.res_err, bus.feat_ready}),
                64'({1'b1, exp_cls, exp_votes, exp_err, 1'b0}));
            chk({name, ":hold_inp"}, 64'(bus.cls_inp), 64'(exp_inp));
        end
        stub_ovr       = 1'b0;
        bus.res_ready  = 1'b1;
        bus.feat_valid = 1'b1;
        bus.feat_data  = FW'(5'd21);
        bus.feat_last  = 1'b0;
        step();
        bus.res_ready  = 1'b0;
        bus.feat_valid = 1'b0;
        chk({name, ":after_hs"},
            64'({bus.res_valid, bus.feat_ready, bus.cls_inp}),
            64'({1'b0, 1'b1, FRAME_W'(0)}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NFEAT-1:0][FW-1:0] rv;
        logic [FRAME_W-1:0]       m_inp;
        logic [CW+VW-1:0]         m_cls;
        int                       rn;
        bit                       rl;

        checks         = 0;
        errors         = 0;
        stub_ovr       = 1'b0;
        ovr_cls        = '0;
        ovr_votes      = '0;
        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.feat_last  = 1'b0;
        bus.res_ready  = 1'b0;
        rst_n          = 1'b0;

        vecs[0] = '{7, 1'b1, '0, '0, 2'd2, 6'b010010, 1'b0};
        vecs[1] = '{7, 1'b1, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
                    {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 2'd2, 6'b010010, 1'b0};
        vecs[2] = '{3, 1'b1, {5'd4, 5'd4, 5'd4, 5'd4, 5'd9, 5'd9, 5'd9},
                    {5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd9, 5'd9}, 2'd0, 6'b100100, 1'b1};
        vecs[3] = '{7, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd17, 5'd3, 5'd20},
                    {5'd0, 5'd0, 5'd0, 5'd0, 5'd17, 5'd3, 5'd20}, 2'd0, 6'b010101, 1'b1};
        vecs[4] = '{7, 1'b1, {7{5'd31}}, {7{5'd31}}, 2'd1, 6'b011000, 1'b0};
        vecs[5] = '{1, 1'b1, {5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd31},
                    {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31}, 2'd0, 6'b100001, 1'b1};

        repeat (3) step();
        rst_n = 1'b1;
        chk_reset("por");

        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].n, vecs[v].last, vecs[v].vals,
                      vecs[v].inp, vecs[v].cls, vecs[v].votes, vecs[v].err, 2, 1'b0, 0);
        end

        run_frame("hold20", vecs[2].n, vecs[2].last, vecs[2].vals, vecs[2].inp,
                  vecs[2].cls, vecs[2].votes, vecs[2].err, 20, 1'b1, 0);

        // Abort mid-frame: the next frame must start again at slot 0.
        send_raw(3, 1'b0);
        do_reset();
        chk_reset("rst_frame");
        no_result("rst_frame", int'(LAT) + 2);
        run_frame("post_rst_frame", vecs[1].n, vecs[1].last, vecs[1].vals, vecs[1].inp,
                  vecs[1].cls, vecs[1].votes, vecs[1].err, 0, 1'b0, 0);

        // Abort two cycles after completion (settle window, or result without settle).
        send_raw(7, 1'b1);
        step();
        step();
        do_reset();
        chk_reset("rst_settle");
        no_result("rst_settle", int'(LAT) + 3);
        run_frame("post_rst_settle", vecs[4].n, vecs[4].last, vecs[4].vals, vecs[4].inp,
                  vecs[4].cls, vecs[4].votes, vecs[4].err, 0, 1'b0, 0);
        no_result("single_result", int'(LAT) + 3);

        // Abort while a result is pending.
        send_raw(7, 1'b1);
        repeat (LAT) step();
        chk("rst_result:pending", 64'(bus.res_valid), 64'(1));
        do_reset();
        chk_reset("rst_result");
        no_result("rst_result", 3);

        // Random frames against the length/packing/error rules.
        for (int r = 0; r < 40; r++) begin
            rn = int'($urandom_range(NFEAT, 1));
            rl = (rn < int'(NFEAT)) ? 1'b1 : 1'($urandom);
            m_inp = '0;
            for (int i = 0; i < int'(NFEAT); i++) rv[i] = FW'($urandom);
            for (int i = 0; i < rn; i++) m_inp = m_inp | (FRAME_W'(rv[i]) << (FW * i));
            m_cls = classify(m_inp);
            run_frame($sformatf("rnd%0d", r), rn, rl, rv, m_inp, m_cls[CW+VW-1:VW],
                      m_cls[VW-1:0], !(rn == int'(NFEAT) && rl),
                      int'($urandom_range(3, 0)), 1'($urandom), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
